// File: rtl/alu_fetch_if.sv
// Handshake and program-load bundle between the fetch stage and its neighbours.
interface alu_fetch_if #(
    parameter int unsigned AW = 4
);
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [9:0]    wr_data;
    logic          start;
    logic [AW:0]   count;
    logic          out_valid;
    logic          out_ready;
    logic [3:0]    out_ain;
    logic [3:0]    out_bin;
    logic [1:0]    out_func;
    logic [AW-1:0] out_pc;
    logic          busy;
    logic          done;

    // Controller / downstream side: drives program load, start and ready.
    modport master (
        output wr_en, wr_addr, wr_data, start, count, out_ready,
        input  out_valid, out_ain, out_bin, out_func, out_pc, busy, done
    );

    // Fetch stage side.
    modport slave (
        input  wr_en, wr_addr, wr_data, start, count, out_ready,
        output out_valid, out_ain, out_bin, out_func, out_pc, busy, done
    );
endinterface

// File: rtl/alu_fetch.sv
// Instruction fetch stage: small program memory stepped by a PC,
// each word presented unpacked on a valid/ready handshake.
module alu_fetch #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    alu_fetch_if.slave  bus
);
    localparam int unsigned WW = 10;
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {IDLE, FETCH, PRESENT, DONE} state_t;

    state_t        state;
    logic [WW-1:0] mem [DEPTH];
    logic [AW-1:0] pc;
    logic [AW-1:0] last_pc;
    logic [WW-1:0] word;
    logic [AW-1:0] word_pc;
    logic          valid;
    logic          busy;
    logic          done;

    assign bus.out_valid = valid;
    assign bus.out_ain   = word[9:6];
    assign bus.out_bin   = word[5:2];
    assign bus.out_func  = word[1:0];
    assign bus.out_pc    = word_pc;
    assign bus.busy      = busy;
    assign bus.done      = done;

    // Program load; locked out while a run is in progress, survives reset.
    always_ff @(posedge clk) begin
        if (bus.wr_en && !busy) begin
            mem[bus.wr_addr] <= bus.wr_data;
        end
    end

    // Sequencer: state, PC and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            pc      <= '0;
            last_pc <= '0;
            word    <= '0;
            word_pc <= '0;
            valid   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (bus.count != '0) begin
                            // Runs longer than the memory are clamped, so pc never wraps.
                            if (bus.count >= CW'(DEPTH)) begin
                                last_pc <= AW'(DEPTH - 1);
                            end else begin
                                last_pc <= AW'(bus.count - CW'(1));
                            end
                            pc    <= '0;
                            busy  <= 1'b1;
                            state <= FETCH;
                        end else begin
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                end
                FETCH: begin
                    // Synchronous read lands directly in the output registers.
                    word    <= mem[pc];
                    word_pc <= pc;
                    valid   <= 1'b1;
                    state   <= PRESENT;
                end
                PRESENT: begin
                    if (bus.out_ready) begin
                        valid <= 1'b0;
                        if (pc == last_pc) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            pc    <= pc + AW'(1);
                            state <= FETCH;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
